// File: rtl/fft_outseq_pkg.sv
// Shared types and defaults for the FFT output segment sequencer.
// Optional feature macro: FFT_OUTSEQ_BYPASS_EN (adds the BYPASS state).
package fft_outseq_pkg;

    localparam int unsigned DEFAULT_DEPTH      = 8;
    localparam int unsigned DEFAULT_NUM_BLOCKS = 8;

    // Counter width for a modulus of n; a 1-bit floor keeps degenerate sizes legal.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEFAULT_BEAT_W  = cnt_width(DEFAULT_DEPTH);
    localparam int unsigned DEFAULT_BLOCK_W = cnt_width(DEFAULT_NUM_BLOCKS);

    // StBypass is only ever entered when FFT_OUTSEQ_BYPASS_EN is defined.
    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StFill   = 2'd1,
        StDrain  = 2'd2,
        StBypass = 2'd3
    } seq_state_e;

endpackage

// File: rtl/fft_outseq_beat_counter.sv
// Wrapping up-counter with synchronous clear (priority over enable) and a
// terminal-count flag at LAST. Used for both the beat and block counters.
module fft_outseq_beat_counter
    import fft_outseq_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_BEAT_W,
    parameter int unsigned LAST  = DEFAULT_DEPTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] LastVal = WIDTH'(LAST);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next count: clear wins, otherwise increment and wrap naturally.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == LastVal);

endmodule

// File: rtl/fft_output_segment_ctrl.sv
// Fill/drain sequencer for the 8-deep FFT output shift segment. Fills the
// chain from upstream, then drains it downstream, NUM_BLOCKS times per frame,
// flagging the final word of the frame on out_last.
// Optional feature macro: FFT_OUTSEQ_BYPASS_EN (direct input->Q streaming).
module fft_output_segment_ctrl
    import fft_outseq_pkg::*;
#(
    parameter int unsigned DEPTH      = DEFAULT_DEPTH,
    parameter int unsigned NUM_BLOCKS = DEFAULT_NUM_BLOCKS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
`ifdef FFT_OUTSEQ_BYPASS_EN
    input  logic                          bypass_mode,
`endif
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          out_last,
    output logic                          seg_hold,
    output logic                          seg_sel,
    output logic [$clog2(NUM_BLOCKS)-1:0] block_idx,
    output logic                          busy
);

    localparam int unsigned BEAT_W  = cnt_width(DEPTH);
    localparam int unsigned BLOCK_W = $clog2(NUM_BLOCKS);
    localparam logic [BEAT_W-1:0]  BeatLast  = BEAT_W'(DEPTH - 1);

    seq_state_e state_q;

    logic              in_acc;
    logic              out_acc;
    logic              start_frame;
    logic              drain_blk_done;
    logic [BEAT_W-1:0] beat_cnt;
    logic              beat_tc;
    logic              beat_en;
    logic              beat_clr;
    logic              block_tc;
    logic              block_en;
    logic              block_clr;

`ifdef FFT_OUTSEQ_BYPASS_EN
    // Bypass Q occupancy and "final word already taken" flag.
    logic byp_valid_q;
    logic byp_last_q;
`endif

    // Handshake-side decodes of the current state.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        seg_sel   = 1'b0;
        unique case (state_q)
            StFill:  in_ready  = 1'b1;
            StDrain: out_valid = 1'b1;
`ifdef FFT_OUTSEQ_BYPASS_EN
            StBypass: begin
                seg_sel   = 1'b1;
                out_valid = byp_valid_q;
                // Stop taking input once the frame's final word is in Q.
                in_ready  = (out_ready | ~byp_valid_q) & ~byp_last_q;
            end
`endif
            default: ;
        endcase
    end

    assign in_acc  = in_valid & in_ready;
    assign out_acc = out_valid & out_ready;

    // Segment hold: chain moves only on an accepted beat of the active phase.
    always_comb begin
        seg_hold = 1'b1;
        unique case (state_q)
            StFill:   seg_hold = ~in_acc;
            StDrain:  seg_hold = ~out_ready;
`ifdef FFT_OUTSEQ_BYPASS_EN
            StBypass: seg_hold = ~in_acc;
`endif
            default:  seg_hold = 1'b1;
        endcase
    end

    // Counter controls: beat advances on every accepted word of the active phase.
    always_comb begin
        start_frame    = (state_q == StIdle) & start;
        drain_blk_done = (state_q == StDrain) & out_acc & beat_tc;
        beat_en        = in_acc | ((state_q == StDrain) & out_acc);
        beat_clr       = start_frame | (beat_en & beat_tc);
        block_en       = drain_blk_done & ~block_tc;
        block_clr      = start_frame | (drain_blk_done & block_tc);
`ifdef FFT_OUTSEQ_BYPASS_EN
        block_en  = block_en | ((state_q == StBypass) & in_acc & beat_tc & ~block_tc);
        block_clr = block_clr | ((state_q == StBypass) & out_acc & byp_last_q);
`endif
    end

    fft_outseq_beat_counter #(
        .WIDTH (BEAT_W),
        .LAST  (DEPTH - 1)
    ) u_beat_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (beat_en),
        .clr   (beat_clr),
        .count (beat_cnt),
        .tc    (beat_tc)
    );

    fft_outseq_beat_counter #(
        .WIDTH (BLOCK_W),
        .LAST  (NUM_BLOCKS - 1)
    ) u_block_cnt (
        .clk   (clk),
        .rst   (rst),
        .en    (block_en),
        .clr   (block_clr),
        .count (block_idx),
        .tc    (block_tc)
    );

    // Sequencer state (plus bypass occupancy tracking when enabled).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
`ifdef FFT_OUTSEQ_BYPASS_EN
            byp_valid_q <= 1'b0;
            byp_last_q  <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
`ifdef FFT_OUTSEQ_BYPASS_EN
                        state_q     <= bypass_mode ? StBypass : StFill;
                        byp_valid_q <= 1'b0;
                        byp_last_q  <= 1'b0;
`else
                        state_q <= StFill;
`endif
                    end
                end
                StFill: begin
                    if (in_acc && beat_tc) begin
                        state_q <= StDrain;
                    end
                end
                StDrain: begin
                    if (out_acc && beat_tc) begin
                        state_q <= block_tc ? StIdle : StFill;
                    end
                end
`ifdef FFT_OUTSEQ_BYPASS_EN
                StBypass: begin
                    byp_valid_q <= in_acc | (byp_valid_q & ~out_ready);
                    if (in_acc && beat_tc && block_tc) begin
                        byp_last_q <= 1'b1;
                    end
                    if (out_acc && byp_last_q) begin
                        state_q    <= StIdle;
                        byp_last_q <= 1'b0;
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q != StIdle);

    // Final word of the frame: last beat of the last block while draining.
    always_comb begin
        out_last = (state_q == StDrain) & block_tc & (beat_cnt == BeatLast);
`ifdef FFT_OUTSEQ_BYPASS_EN
        out_last = out_last | ((state_q == StBypass) & byp_valid_q & byp_last_q);
`endif
    end

endmodule

// File: tb/tb_fft_output_segment_ctrl.sv
// Bench for fft_output_segment_ctrl: a plant model of the 8-deep segment is
// driven by seg_hold/seg_sel, and a frame-level model (word counts in/out,
// fill-vs-drain phase) predicts every output each cycle.
`timescale 1ns/1ps
module tb_fft_output_segment_ctrl;

    localparam int DEPTH = 8;
    localparam int NB    = 8;
    localparam int FRAME = DEPTH * NB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready, out_valid, out_last, seg_hold, seg_sel, busy;
    logic [2:0] block_idx;
`ifdef FFT_OUTSEQ_BYPASS_EN
    logic       bypass_mode = 1'b0;
`endif

    fft_output_segment_ctrl #(
        .DEPTH      (DEPTH),
        .NUM_BLOCKS (NB)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
`ifdef FFT_OUTSEQ_BYPASS_EN
        .bypass_mode (bypass_mode),
`endif
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_last    (out_last),
        .seg_hold    (seg_hold),
        .seg_sel     (seg_sel),
        .block_idx   (block_idx),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Plant: the shift segment itself; each accepted upstream word is its index.
    int seg [DEPTH];
    int plant_in;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            plant_in <= 0;
        end else begin
            if (start && !busy) plant_in <= 0;
            else if (in_valid && in_ready) plant_in <= plant_in + 1;
            if (!seg_hold) begin
                if (seg_sel) begin
                    seg[0] <= plant_in;
                end else begin
                    for (int i = 0; i < DEPTH - 1; i++) seg[i] <= seg[i+1];
                    seg[DEPTH-1] <= plant_in;
                end
            end
        end
    end

    // Frame-level model: phase flips after every DEPTH words in or out.
    bit m_busy = 0, m_fill = 0, model_on = 1;
    bit m_ir, m_ov;
    int n_in = 0, n_out = 0;
    int cyc = 0, first_ov_cyc = -1, first_q = -1, last_seen = 0, out_hs_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            check("rst_in_ready", in_ready, 0);
            check("rst_out_valid", out_valid, 0);
            check("rst_out_last", out_last, 0);
            check("rst_seg_hold", seg_hold, 1);
            check("rst_seg_sel", seg_sel, 0);
            check("rst_block_idx", block_idx, 0);
            check("rst_busy", busy, 0);
            m_busy = 0;
            m_fill = 0;
            n_in   = 0;
            n_out  = 0;
        end else if (model_on) begin
            m_ir = m_busy && m_fill;
            m_ov = m_busy && !m_fill;
            check("in_ready", in_ready, m_ir);
            check("out_valid", out_valid, m_ov);
            check("busy", busy, m_busy);
            check("block_idx", block_idx, m_busy ? (n_out / DEPTH) % NB : 0);
            check("seg_sel", seg_sel, 0);
            check("seg_hold", seg_hold, !m_busy ? 1 : (m_fill ? !in_valid : !out_ready));
            check("out_last", out_last, (m_ov && n_out == FRAME - 1) ? 1 : 0);
            if (m_ov) check("q_word", seg[0], n_out);
            if (out_valid && out_ready) out_hs_cnt++;
            if (out_last && out_ready) last_seen++;
            if (out_valid && first_ov_cyc < 0) begin
                first_ov_cyc = cyc;
                first_q      = seg[0];
            end
            // Advance the model across the coming edge.
            if (!m_busy) begin
                if (start) begin
                    m_busy = 1;
                    m_fill = 1;
                    n_in   = 0;
                    n_out  = 0;
                end
            end else begin
                if (m_ir && in_valid) begin
                    n_in++;
                    if (n_in % DEPTH == 0) m_fill = 0;
                end
                if (m_ov && out_ready) begin
                    n_out++;
                    if (n_out % DEPTH == 0) m_fill = 1;
                    if (n_out == FRAME) m_busy = 0;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_frame();
        first_ov_cyc = -1;
        first_q      = -1;
        last_seen    = 0;
        out_hs_cnt   = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Run with random stalls (percent of cycles each side is held off).
    task automatic run_until_idle(input int pin, input int pout);
        int guard = 0;
        while (m_busy && guard < 4000) begin
            in_valid  = ($urandom_range(0, 99) >= pin);
            out_ready = ($urandom_range(0, 99) >= pout);
            tick();
            guard++;
        end
        if (m_busy) begin
            checks++;
            errors++;
            $display("FAIL frame_timeout: still busy after %0d cycles, required idle", guard);
        end
    endtask

    task automatic frame_summary(input string tag);
        check({tag, "_out_count"}, out_hs_cnt, FRAME);
        check({tag, "_last_count"}, last_seen, 1);
        check({tag, "_busy_end"}, busy, 0);
    endtask

    initial begin
        int start_cyc;
        int g;
        #1 rst = 1'b0;
        repeat (3) tick();
        check("pin_reset_busy", busy, 0);
        check("pin_reset_hold", seg_hold, 1);
        rst = 1'b1;
        tick();

        // Full rate: first out_valid 9 cycles after start, word 0 on Q.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        start_cyc = cyc;
        new_frame();
        check("pin_start_to_in_ready", in_ready, 1);
        run_until_idle(0, 0);
        check("pin_first_ov_latency", first_ov_cyc - start_cyc, 9);
        check("pin_first_q", first_q, 0);
        frame_summary("full");

        // Random 30% stalls on both sides.
        new_frame();
        run_until_idle(30, 30);
        frame_summary("stall");

        // start during DRAIN of block 3 is ignored.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        new_frame();
        g = 0;
        while (!(block_idx == 3 && out_valid) && g < 500) begin tick(); g++; end
        check("pin_blk3_reached", block_idx, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("pin_blk3_still_busy", busy, 1);
        check("pin_blk3_still_draining", out_valid, 1);
        g = 0;
        while (!in_ready && g < 500) begin tick(); g++; end
        check("pin_blk_after_ignore", block_idx, 4);
        run_until_idle(0, 0);
        frame_summary("ignore");

        // Reset mid-FILL of block 5, beat 4.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        new_frame();
        g = 0;
        while (!(m_fill && n_out == 40 && n_in == 44) && g < 500) begin tick(); g++; end
        check("pin_blk5_fill", block_idx, 5);
        check("pin_blk5_in_ready", in_ready, 1);
        #2 rst = 1'b0;
        #1;
        check("async_in_ready", in_ready, 0);
        check("async_out_valid", out_valid, 0);
        check("async_out_last", out_last, 0);
        check("async_seg_hold", seg_hold, 1);
        check("async_block_idx", block_idx, 0);
        check("async_busy", busy, 0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        new_frame();
        run_until_idle(0, 0);
        frame_summary("post_rst");

        // Downstream stalled for 100 cycles at DRAIN beat 0.
        in_valid  = 1'b1;
        out_ready = 1'b0;
        new_frame();
        g = 0;
        while (!out_valid && g < 100) begin tick(); g++; end
        repeat (100) tick();
        check("pin_stall_q", seg[0], 0);
        check("pin_stall_hold", seg_hold, 1);
        check("pin_stall_ov", out_valid, 1);
        run_until_idle(0, 0);
        frame_summary("long_stall");

`ifdef FFT_OUTSEQ_BYPASS_EN
        // Bypass: each accepted word appears on Q one cycle later.
        model_on    = 0;
        bypass_mode = 1'b1;
        in_valid    = 1'b1;
        out_ready   = 1'b1;
        new_frame();
        for (int w = 0; w < FRAME; w++) begin
            tick();
            check("byp_ov", out_valid, 1);
            check("byp_q", seg[0], w);
            check("byp_sel", seg_sel, 1);
            check("byp_last", out_last, (w == FRAME - 1) ? 1 : 0);
        end
        tick();
        check("byp_idle", busy, 0);
        bypass_mode = 1'b0;
        model_on    = 1;
`endif

        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fft_output_segment_ctrl.md
# fft_output_segment_ctrl

Sequencer for the FFT output segment, an 8-deep shift chain with per-stage `hold` and an output-stage input select. It fills the chain from the upstream result bus with a valid/ready handshake, then drains it to the downstream consumer. It repeats this for NUM_BLOCKS blocks per frame and flags the last word of each 64-point frame. It sits between the final butterfly stage and the output port, and owns the segment's `hold` and `sel` pins.

## Interface
- DEPTH, 8, stages in the controlled segment (power of two, ≥2)
- NUM_BLOCKS, 8, blocks per frame (DEPTH×NUM_BLOCKS = 64 points)
- clk  input  1  clock, rising edge
- rst  input  1  reset; asynchronous, active-low
- start  input  1  one-cycle pulse that begins a frame; ignored unless in IDLE
- in_valid  input  1  upstream word valid
- in_ready  output  1  upstream word accepted when in_valid & in_ready
- out_valid  output  1  segment output Q holds a valid word
- out_ready  input  1  downstream accepts when out_valid & out_ready
- out_last  output  1  asserted with the final word of the frame
- seg_hold  output  1  to segment `hold`; 1 freezes all stages
- seg_sel  output  1  to segment `sel`; 0 = shift (stage1→Q), 1 = direct input→Q
- block_idx  output  $clog2(NUM_BLOCKS)  current block within the frame
- busy  output  1  high outside IDLE
- bypass_mode  input  1  present only with FFT_OUTSEQ_BYPASS_EN

## Operation
- States: IDLE, FILL, DRAIN; BYPASS only when the macro is defined.
- IDLE:
  - in_ready=0, out_valid=0, seg_hold=1.
  - start moves to FILL and clears the beat counter and block_idx.
  - With the macro, start & bypass_mode moves to BYPASS instead.
- FILL:
  - in_ready=1, seg_sel=0.
  - seg_hold = ~(in_valid & in_ready).
  - Each accept increments beat_cnt.
  - On the DEPTH-th accept, clear beat_cnt and go to DRAIN.
  - Result: stage0 (Q) = word0 and stage DEPTH-1 = word DEPTH-1.
- DRAIN:
  - out_valid=1, in_ready=0, seg_sel=0.
  - seg_hold = ~out_ready.
  - Each accept increments beat_cnt.
  - On the DEPTH-th accept:
    - If block_idx = NUM_BLOCKS-1: go to IDLE and clear block_idx.
    - Otherwise: block_idx+1 and go to FILL.
- out_last = DRAIN & block_idx=NUM_BLOCKS-1 & beat_cnt=DEPTH-1.
- FILL and DRAIN never overlap (half-duplex). Input is never accepted while output is pending.
- beat_cnt is $clog2(DEPTH) bits and wraps naturally at DEPTH; no saturation.
- start while busy is ignored; there is no queuing.
- Holding off in_valid or out_ready for any number of cycles stalls the chain. No data is lost or duplicated.

## Timing
- All outputs are registered state decodes or combinational from state and handshake inputs. seg_hold depends combinationally on in_valid and out_ready.
- Reset values: state=IDLE, in_ready=0, out_valid=0, out_last=0, seg_hold=1, seg_sel=0, block_idx=0, busy=0.
- Latency:
  - start → in_ready=1: 1 cycle.
  - DEPTH-th fill accept → out_valid=1: next cycle, with word0 on Q.
- Full-rate throughput is 2×DEPTH cycles per block with no stalls.
- Reset asserted mid-frame returns to IDLE immediately. The partial frame is discarded with no out_last. Segment contents are don't-care.

## Configuration
- Macro: FFT_OUTSEQ_BYPASS_EN.
- Defined:
  - bypass_mode port exists.
  - BYPASS state: seg_sel=1, out_valid registered.
  - in_ready = out_ready | ~out_valid.
  - An accepted word loads Q directly, giving 1-cycle latency.
  - A frame is DEPTH×NUM_BLOCKS accepts; out_last is on the final word.
  - After the final word drains, return to IDLE.
- Undefined: no port, no BYPASS state, seg_sel tied 0.

## Structure
- Package fft_outseq_pkg holds:
  - state enum (IDLE, FILL, DRAIN, BYPASS).
  - DEPTH/NUM_BLOCKS defaults and derived counter widths.
- Sub-module fft_outseq_beat_counter: enable/clear/terminal-count counter, instanced for beat_cnt and block_idx.

## Test plan
- Reset, then start with in_valid=1 and out_ready=1 constant, feeding 0..63 → out_valid first high 9 cycles after start. Q emits 0..63 in order. out_last is high only on 63. Back in IDLE with busy=0.
- Random in_valid/out_ready stalls (30% duty) → same 0..63 order. seg_hold=1 on every stalled cycle. No duplicates.
- start pulsed during DRAIN of block 3 → ignored; block_idx continues 3→4.
- rst low during FILL of block 5 (beat 4) → all outputs at reset values in the same cycle. A new start produces a clean 0..63 frame.
- out_ready=0 for 100 cycles at DRAIN beat 0 → Q stable at word0, seg_hold=1 throughout, out_valid stays 1.
- (FFT_OUTSEQ_BYPASS_EN) bypass_mode=1, start, 64 words at full rate → each word on Q one cycle after accept. seg_sel=1 throughout. out_last on word 63.
